pvar_swap_pipe: RTL and testbench
=================================

Name: pvar_swap_pipe

Overview:
- Parametrised successor to the single-bit pair-select state machine. It generalises the 1-bit state to a D-deep, W-bit shift pipeline.
- A per-sample swap control exchanges the newest pair of samples. The block tracks occupancy with a fill-phase state machine.
- Sits between a data source and a consumer. It is used as a polymorphic-width reorder/delay stage in generated designs.

Parameters:
- W, 8: data width in bits (>=1).
- D, 4: pipeline depth in slots (>=2).
- RST_VAL, 0: W-bit reset value loaded into every slot and into __out0.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- __in0  input  W  sample data.
- __in1  input  1  sample valid.
- __in2  input  1  swap request; qualified by accept.
- __in3  input  1  hold; blocks accept.
- __out0  output  W  evicted sample, registered.
- __out1  output  1  evicted-sample valid, registered, one-cycle pulse.
- __out2  output  2  phase: 0=EMPTY, 1=FILL, 2=FULL.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst=0:
  - all slots sr[0..D-1]=RST_VAL, count=0, phase=EMPTY;
  - __out0=RST_VAL, __out1=0, __out2=0.
  - Reset asserted mid-operation discards all contents immediately; no eviction pulse is produced.
- Accept: accept = __in1 & ~__in3. With no accept, every register holds and __out1<=0.
- Shift on accept:
  - sr[k] <= sr[k-1] for k=2..D-1.
  - sr[1] <= swap_eff ? __in0 : sr[0].
  - sr[0] <= swap_eff ? sr[0] : __in0.
  - swap_eff = __in2 & (count>=1). Swap is ignored when the pipe is empty, because sr[0] holds no valid sample.
- Occupancy: count increments on accept while count<D and saturates at D.
- Eviction: on accept with count==D (pre-update), __out0<=sr[D-1] (pre-shift) and __out1<=1 in the same edge. Result is visible the cycle after the accept.
- Latency: a sample not displaced by a swap is evicted on the D-th accept after its own. Output is registered (1 cycle).
- Phase FSM, next state evaluated on accept only:
  - EMPTY -> FILL on accept.
  - FILL -> FULL when count becomes D.
  - FILL stays FILL otherwise.
  - FULL stays FULL; there is no drain path.
  - __out2 is registered and encodes the current phase.
- Simultaneous events:
  - valid & hold: no accept.
  - swap without valid: ignored.
  - swap on the accept that fills the pipe: applied normally.
  - swap on an evicting accept: applied to sr[0]/sr[1] only; it never affects the evicted sample.
- Widths: count is $clog2(D+1) bits, unsigned, no wrap (saturating).

Optional Feature:
- Macro PVAR_STATUS_EN, when defined, adds two registered outputs:
  - __out3, $clog2(D+1) bits: current count.
  - __out4, 1 bit: sticky drop flag. Set on any cycle with __in1=1 & __in3=1. Cleared only by reset.
- Without the macro, neither port exists and no drop-flag register is built. Core behaviour is identical either way.

Decomposition:
- Package pvar_pkg holds:
  - typedef phase_e {EMPTY=2'd0, FILL=2'd1, FULL=2'd2};
  - localparam-style helper for count width;
  - the phase encoding constants used by the bench.
- One sub-module is natural: pvar_swap_slot. It contains the sr[0]/sr[1] pair with its swap mux, parametrised by W.

Test Plan:
- W=8, D=4; reset low then high; push 0x11,0x22,0x33,0x44 with no swap -> __out2 goes 1 then 2 after the 4th accept; __out1 stays 0.
- Continue with push 0x55 -> next cycle __out1=1, __out0=0x11; a further push of 0x66 -> __out0=0x22.
- From reset, push 0xA1, then 0xA2 with swap=1, then 0xA3, 0xA4, 0xA5, 0xA6 -> eviction order 0xA2, then 0xA1.
- From reset, push 0x01 with swap=1 -> swap ignored; sr[0]=0x01 and count=1.
- Hold=1 with valid=1 for 3 cycles while FULL -> no output pulse, contents unchanged. With PVAR_STATUS_EN, __out4=1 and __out3=4.
- Assert rst low asynchronously mid-stream, between clock edges -> __out1=0, __out2=0, __out0=RST_VAL immediately. The first subsequent accept yields phase FILL.

Source files
------------

// File: rtl/pvar_pkg.sv
// Shared definitions for the pvar swap pipeline: phase encoding and a helper
// that sizes the occupancy counter for a given depth.
package pvar_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } phase_e;

    localparam logic [1:0] PH_EMPTY = 2'(EMPTY);
    localparam logic [1:0] PH_FILL  = 2'(FILL);
    localparam logic [1:0] PH_FULL  = 2'(FULL);

    // Bits needed to hold an occupancy value from 0 up to and including depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pvar_swap_slot.sv
// Front pair of the swap pipeline: slot 0 (newest) and slot 1. When swap is
// set on an enabled cycle, the incoming sample lands in slot 1 and slot 0
// keeps its value, so the two newest samples leave the pipe in reversed order.
module pvar_swap_slot
    import pvar_pkg::*;
#(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         swap,
    input  logic [W-1:0] din,
    output logic [W-1:0] q0,
    output logic [W-1:0] q1
);

    // Load the newest pair, exchanging positions when a swap is requested.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q0 <= RST_VAL;
            q1 <= RST_VAL;
        end else if (en) begin
            q1 <= swap ? din : q0;
            q0 <= swap ? q0  : din;
        end
    end

endmodule

// File: rtl/pvar_swap_pipe.sv
// D-deep, W-bit reorder/delay pipeline with a swap control on the newest pair
// and a fill-phase tracker. Once full, each accept evicts the oldest sample
// as a registered one-cycle pulse.
// Optional build macro PVAR_STATUS_EN adds the count output (__out3) and a
// sticky drop flag (__out4) that records any valid sample refused by hold.
module pvar_swap_pipe
    import pvar_pkg::*;
#(
    parameter int           W       = 8,
    parameter int           D       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             __in0,
    input  logic                     __in1,
    input  logic                     __in2,
    input  logic                     __in3,
    output logic [W-1:0]             __out0,
    output logic                     __out1,
    output logic [1:0]               __out2
`ifdef PVAR_STATUS_EN
    ,
    output logic [$clog2(D+1)-1:0]   __out3,
    output logic                     __out4
`endif
);

    localparam int CW = count_width(D);

    logic          accept;
    logic          swap_eff;
    logic          full;
    logic [CW-1:0] count;
    logic [1:0]    phase;
    logic [W-1:0]  slot0;
    logic [W-1:0]  slot1;
    logic [W-1:0]  oldest;

    assign accept   = __in1 & ~__in3;
    assign full     = (count == CW'(D));
    // An empty pipe has nothing valid in slot 0 to exchange with.
    assign swap_eff = __in2 & (count != '0);

    pvar_swap_slot #(
        .W       (W),
        .RST_VAL (RST_VAL)
    ) u_slot (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .swap (swap_eff),
        .din  (__in0),
        .q0   (slot0),
        .q1   (slot1)
    );

    generate
        if (D > 2) begin : g_tail
            logic [W-1:0] tail [2:D-1];

            // Plain delay slots behind the swap pair, shifted on every accept.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 2; k < D; k++) tail[k] <= RST_VAL;
                end else if (accept) begin
                    tail[2] <= slot1;
                    for (int k = 3; k < D; k++) tail[k] <= tail[k-1];
                end
            end

            assign oldest = tail[D-1];
        end else begin : g_no_tail
            assign oldest = slot1;
        end
    endgenerate

    // Saturating occupancy counter; it never wraps and has no drain path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (accept && !full) begin
            count <= count + CW'(1);
        end
    end

    // Evict the pre-shift oldest sample when accepting into a full pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            __out0 <= RST_VAL;
            __out1 <= 1'b0;
        end else begin
            __out1 <= accept & full;
            if (accept && full) begin
                __out0 <= oldest;
            end
        end
    end

    // Fill-phase tracker, advanced only on accepted samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= PH_EMPTY;
        end else if (accept) begin
            case (phase)
                PH_EMPTY: phase <= PH_FILL;
                PH_FILL:  if (count == CW'(D - 1)) phase <= PH_FULL;
                default:  phase <= phase;
            endcase
        end
    end

    assign __out2 = phase;

`ifdef PVAR_STATUS_EN
    logic drop;

    // Remember any cycle where a valid sample was refused because of hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop <= 1'b0;
        end else if (__in1 && __in3) begin
            drop <= 1'b1;
        end
    end

    assign __out3 = count;
    assign __out4 = drop;
`endif

endmodule

// File: tb/tb_pvar_swap_pipe.sv
// Self-checking bench for pvar_swap_pipe (W=8, D=4): directed vector tables
// with fixed expectations, an asynchronous mid-stream reset sequence, and a
// randomized stream checked against a reference model through a scoreboard.
// Status outputs are checked when built with PVAR_STATUS_EN.
module tb_pvar_swap_pipe;
    import pvar_pkg::*;

    localparam int           W  = 8;
    localparam int           D  = 4;
    localparam int           CW = $clog2(D + 1);
    localparam logic [W-1:0] RV = 8'h00;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  in0 = '0;
    logic          in1 = 1'b0;
    logic          in2 = 1'b0;
    logic          in3 = 1'b0;
    logic [W-1:0]  out0;
    logic          out1;
    logic [1:0]    out2;
`ifdef PVAR_STATUS_EN
    logic [CW-1:0] out3;
    logic          out4;
`endif

    pvar_swap_pipe #(.W(W), .D(D), .RST_VAL(RV)) dut (
        .clk    (clk),
        .rst    (rst),
        .__in0  (in0),
        .__in1  (in1),
        .__in2  (in2),
        .__in3  (in3),
        .__out0 (out0),
        .__out1 (out1),
        .__out2 (out2)
`ifdef PVAR_STATUS_EN
        ,
        .__out3 (out3),
        .__out4 (out4)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_before;
        logic          v;
        logic          s;
        logic          h;
        logic [W-1:0]  d;
        logic          exp_v;
        logic [W-1:0]  exp_d;
        logic [1:0]    exp_ph;
        logic [CW-1:0] exp_cnt;
        logic          exp_drop;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] sb_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state for the randomized stream.
    logic [W-1:0] m [D];
    int           m_cnt;
    logic         m_drop;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the DUT take an edge, then settle past it.
    task automatic applyStimulus(input logic v, input logic s, input logic h, input logic [W-1:0] d);
        in1 = v;
        in2 = s;
        in3 = h;
        in0 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        in1 = 1'b0;
        in2 = 1'b0;
        in3 = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_out1", 32'(out1), 32'(1'b0));
        checkOutput("reset_out2", 32'(out2), 32'(PH_EMPTY));
        checkOutput("reset_out0", 32'(out0), 32'(RV));
`ifdef PVAR_STATUS_EN
        checkOutput("reset_out3", 32'(out3), 32'd0);
        checkOutput("reset_out4", 32'(out4), 32'd0);
`endif
        rst = 1'b1;
        for (int k = 0; k < D; k++) m[k] = RV;
        m_cnt  = 0;
        m_drop = 1'b0;
        sb_q.delete();
    endtask

    function automatic vec_t mk(input logic rb, input logic v, input logic s, input logic h,
                                input logic [W-1:0] d, input logic ev, input logic [W-1:0] ed,
                                input logic [1:0] ph, input int cnt, input logic drp);
        vec_t t;
        t.rst_before = rb;
        t.v          = v;
        t.s          = s;
        t.h          = h;
        t.d          = d;
        t.exp_v      = ev;
        t.exp_d      = ed;
        t.exp_ph     = ph;
        t.exp_cnt    = CW'(cnt);
        t.exp_drop   = drp;
        return t;
    endfunction

    initial begin
        // Sequence 1: plain fill, evictions, hold while full, swap without valid.
        vecs.push_back(mk(1, 1, 0, 0, 8'h11, 0, 8'h00, 2'd1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h22, 0, 8'h00, 2'd1, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h33, 0, 8'h00, 2'd1, 3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h44, 0, 8'h00, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h55, 1, 8'h11, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h66, 1, 8'h22, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'hEE, 0, 8'h00, 2'd2, 4, 1));
        vecs.push_back(mk(0, 1, 1, 1, 8'hED, 0, 8'h00, 2'd2, 4, 1));
        vecs.push_back(mk(0, 1, 0, 1, 8'hEC, 0, 8'h00, 2'd2, 4, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'hEF, 0, 8'h00, 2'd2, 4, 1));
        vecs.push_back(mk(0, 1, 0, 0, 8'h77, 1, 8'h33, 2'd2, 4, 1));
        // Sequence 2: swap during fill and swap on an evicting accept.
        vecs.push_back(mk(1, 1, 0, 0, 8'hA1, 0, 8'h00, 2'd1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'hA2, 0, 8'h00, 2'd1, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'hA3, 0, 8'h00, 2'd1, 3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'hA4, 0, 8'h00, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'hA5, 1, 8'hA2, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'hA6, 1, 8'hA1, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'hA7, 1, 8'hA3, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'hA8, 1, 8'hA4, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'hA9, 1, 8'hA5, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'hB0, 1, 8'hA6, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'hB1, 1, 8'hA8, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'hB2, 1, 8'hA7, 2'd2, 4, 0));
        // Sequence 3: swap on an empty pipe is ignored.
        vecs.push_back(mk(1, 1, 1, 0, 8'h01, 0, 8'h00, 2'd1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h02, 0, 8'h00, 2'd1, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h03, 0, 8'h00, 2'd1, 3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h04, 0, 8'h00, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h05, 1, 8'h01, 2'd2, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h06, 1, 8'h02, 2'd2, 4, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) doReset();
            applyStimulus(vecs[i].v, vecs[i].s, vecs[i].h, vecs[i].d);
            checkOutput($sformatf("vec%0d_out1", i), 32'(out1), 32'(vecs[i].exp_v));
            checkOutput($sformatf("vec%0d_out2", i), 32'(out2), 32'(vecs[i].exp_ph));
            if (vecs[i].exp_v) checkOutput($sformatf("vec%0d_out0", i), 32'(out0), 32'(vecs[i].exp_d));
`ifdef PVAR_STATUS_EN
            checkOutput($sformatf("vec%0d_out3", i), 32'(out3), 32'(vecs[i].exp_cnt));
            checkOutput($sformatf("vec%0d_out4", i), 32'(out4), 32'(vecs[i].exp_drop));
`endif
        end

        // Asynchronous reset between edges while an eviction pulse is showing.
        in1 = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_out1", 32'(out1), 32'(1'b0));
        checkOutput("async_out2", 32'(out2), 32'(PH_EMPTY));
        checkOutput("async_out0", 32'(out0), 32'(RV));
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h10);
        checkOutput("post_async_out2", 32'(out2), 32'(PH_FILL));
        checkOutput("post_async_out1", 32'(out1), 32'(1'b0));
`ifdef PVAR_STATUS_EN
        checkOutput("post_async_out3", 32'(out3), 32'd1);
`endif

        // Randomized stream against the reference model and scoreboard.
        doReset();
        for (int n = 0; n < 400; n++) begin
            logic         v, s, h, acc, ev;
            logic [W-1:0] d;
            v   = ($urandom_range(0, 3) != 0);
            s   = ($urandom_range(0, 2) == 0);
            h   = ($urandom_range(0, 4) == 0);
            d   = W'($urandom_range(0, 255));
            acc = v & ~h;
            ev  = 1'b0;
            if (v && h) m_drop = 1'b1;
            if (acc) begin
                if (m_cnt == D) begin
                    sb_q.push_back(m[D-1]);
                    ev = 1'b1;
                end
                for (int k = D - 1; k >= 2; k--) m[k] = m[k-1];
                if (s && m_cnt >= 1) begin
                    m[1] = d;
                end else begin
                    m[1] = m[0];
                    m[0] = d;
                end
                if (m_cnt < D) m_cnt++;
            end
            applyStimulus(v, s, h, d);
            checkOutput("rand_out1", 32'(out1), 32'(ev));
            if (out1) begin
                if (sb_q.size() > 0) begin
                    checkOutput("rand_out0", 32'(out0), 32'(sb_q.pop_front()));
                end else begin
                    checkOutput("rand_unexpected_evict", 32'(out1), 32'(1'b0));
                end
            end
            checkOutput("rand_out2", 32'(out2),
                        32'((m_cnt == 0) ? PH_EMPTY : (m_cnt == D) ? PH_FULL : PH_FILL));
`ifdef PVAR_STATUS_EN
            checkOutput("rand_out3", 32'(out3), 32'(m_cnt));
            checkOutput("rand_out4", 32'(out4), 32'(m_drop));
`endif
        end
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
